// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V tile: loader state encoding, data width
// and the uio_in pin positions of the loader control inputs.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam int LD_STB_BIT = 0;
    localparam int RUN_BIT    = 1;
    localparam int STOP_BIT   = 2;

    typedef enum logic [1:0] {
        LDR_IDLE     = 2'd0,
        LDR_ASSEMBLE = 2'd1,
        LDR_WRITE    = 2'd2,
        LDR_RUN      = 2'd3
    } ldr_state_e;

endpackage

// File: rtl/riscv_prog_loader_if.sv
// Instruction-memory write port between the program loader (master) and the
// core's imem (slave).
interface riscv_prog_loader_if
    import riscv_pkg::*;
#(
    parameter int IMEM_AW = 5
);
    logic                 we;
    logic [IMEM_AW-1:0]   waddr;
    logic [XLEN-1:0]      wdata;

    modport master (output we, waddr, wdata);
    modport slave  (input  we, waddr, wdata);
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous level, followed by a
// rising-edge detector producing a single-cycle pulse.
module sync_edge_det #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);
    logic [SYNC_STG-1:0] sync_reg;
    logic                prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STG-2:0], din};
            prev_reg <= sync_reg[SYNC_STG-1];
        end
    end

    assign pulse = sync_reg[SYNC_STG-1] & ~prev_reg;
endmodule

// File: rtl/riscv_prog_loader.sv
// Byte-serial program loader: packs little-endian bytes into 32-bit imem
// words, holds the core in reset while loading and sequences run/stop.
module riscv_prog_loader
    import riscv_pkg::*;
#(
    parameter int IMEM_AW  = 5,
    parameter int SYNC_STG = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [7:0]            ld_data,
    input  logic                  ld_strobe,
    input  logic                  run_req,
    input  logic                  stop_req,
    riscv_prog_loader_if.master   imem,
    output logic                  core_rst_n,
    output logic                  loading,
    output logic [IMEM_AW:0]      word_cnt,
    output logic                  err_ovf,
    output logic                  err_partial
);
    localparam logic [1:0] ST_IDLE     = LDR_IDLE;
    localparam logic [1:0] ST_ASSEMBLE = LDR_ASSEMBLE;
    localparam logic [1:0] ST_WRITE    = LDR_WRITE;
    localparam logic [1:0] ST_RUN      = LDR_RUN;

    localparam logic [IMEM_AW:0] FULL_CNT = {1'b1, {IMEM_AW{1'b0}}};

    logic [2:0] raw_in;
    logic [2:0] edge_raw;
    logic       byte_ev, run_ev, stop_ev;

    assign raw_in[LD_STB_BIT] = ld_strobe;
    assign raw_in[RUN_BIT]    = run_req;
    assign raw_in[STOP_BIT]   = stop_req;

    // Synchronizers run regardless of ena so that edges seen while disabled are consumed, not deferred.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        sync_edge_det #(.SYNC_STG(SYNC_STG)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (raw_in[gi]),
            .pulse (edge_raw[gi])
        );
    end

    assign byte_ev = edge_raw[LD_STB_BIT] & ena;
    assign run_ev  = edge_raw[RUN_BIT]    & ena;
    assign stop_ev = edge_raw[STOP_BIT]   & ena;

    logic [1:0]         state_reg,       state_next;
    logic [1:0]         byte_idx_reg,    byte_idx_next;
    logic [XLEN-1:0]    wdata_reg,       wdata_next;
    logic [IMEM_AW-1:0] waddr_reg,       waddr_next;
    logic [IMEM_AW:0]   word_cnt_reg,    word_cnt_next;
    logic               run_pend_reg,    run_pend_next;
    logic               err_ovf_reg,     err_ovf_next;
    logic               err_partial_reg, err_partial_next;

    always_comb begin
        state_next       = state_reg;
        byte_idx_next    = byte_idx_reg;
        wdata_next       = wdata_reg;
        waddr_next       = waddr_reg;
        word_cnt_next    = word_cnt_reg;
        run_pend_next    = run_pend_reg;
        err_ovf_next     = err_ovf_reg;
        err_partial_next = err_partial_reg;

        case (state_reg)
            ST_IDLE, ST_ASSEMBLE: begin
                // A run request outranks a coincident byte; any partial word is discarded.
                if (run_ev || run_pend_reg) begin
                    state_next    = ST_RUN;
                    run_pend_next = 1'b0;
                    if (byte_idx_reg != 2'd0) begin
                        err_partial_next = 1'b1;
                        byte_idx_next    = 2'd0;
                    end
                end else if (byte_ev) begin
                    if (state_reg == ST_IDLE && word_cnt_reg == FULL_CNT) begin
                        err_ovf_next = 1'b1;
                    end else begin
                        wdata_next[8*byte_idx_reg +: 8] = ld_data;
                        if (byte_idx_reg == 2'd3) begin
                            byte_idx_next = 2'd0;
                            state_next    = ST_WRITE;
                        end else begin
                            byte_idx_next = byte_idx_reg + 2'd1;
                            state_next    = ST_ASSEMBLE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                waddr_next    = waddr_reg + IMEM_AW'(1);
                word_cnt_next = word_cnt_reg + (IMEM_AW+1)'(1);
                state_next    = ST_IDLE;
                if (run_ev) begin
                    run_pend_next = 1'b1;
                end
            end
            default: begin
                if (stop_ev) begin
                    state_next    = ST_IDLE;
                    waddr_next    = '0;
                    word_cnt_next = '0;
                    byte_idx_next = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            byte_idx_reg    <= 2'd0;
            wdata_reg       <= '0;
            waddr_reg       <= '0;
            word_cnt_reg    <= '0;
            run_pend_reg    <= 1'b0;
            err_ovf_reg     <= 1'b0;
            err_partial_reg <= 1'b0;
        end else if (ena) begin
            state_reg       <= state_next;
            byte_idx_reg    <= byte_idx_next;
            wdata_reg       <= wdata_next;
            waddr_reg       <= waddr_next;
            word_cnt_reg    <= word_cnt_next;
            run_pend_reg    <= run_pend_next;
            err_ovf_reg     <= err_ovf_next;
            err_partial_reg <= err_partial_next;
        end
    end

    assign imem.we     = (state_reg == ST_WRITE) & ena;
    assign imem.waddr  = waddr_reg;
    assign imem.wdata  = wdata_reg;
    // The core goes back into reset in the very cycle the stop edge is seen.
    assign core_rst_n  = (state_reg == ST_RUN) & ~stop_ev;
    assign loading     = (state_reg != ST_RUN);
    assign word_cnt    = word_cnt_reg;
    assign err_ovf     = err_ovf_reg;
    assign err_partial = err_partial_reg;
endmodule

// File: tb/tb_riscv_prog_loader.sv
// Directed bench for riscv_prog_loader with a 4-word imem (IMEM_AW=2).
module tb_riscv_prog_loader;
    import riscv_pkg::*;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [7:0]    ld_data;
    logic [7:0]    uio;
    logic          ld_strobe, run_req, stop_req;
    logic          core_rst_n, loading, err_ovf, err_partial;
    logic [AW:0]   word_cnt;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [AW-1:0] addr_log [64];
    logic [31:0]   data_log [64];

    assign ld_strobe = uio[LD_STB_BIT];
    assign run_req   = uio[RUN_BIT];
    assign stop_req  = uio[STOP_BIT];

    riscv_prog_loader_if #(.IMEM_AW(AW)) imem ();

    riscv_prog_loader #(.IMEM_AW(AW), .SYNC_STG(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .ld_data     (ld_data),
        .ld_strobe   (ld_strobe),
        .run_req     (run_req),
        .stop_req    (stop_req),
        .imem        (imem),
        .core_rst_n  (core_rst_n),
        .loading     (loading),
        .word_cnt    (word_cnt),
        .err_ovf     (err_ovf),
        .err_partial (err_partial)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem.we === 1'b1) begin
            $display("imem write #%0d addr=%0d data=%08h", we_cnt, imem.waddr, imem.wdata);
            if (we_cnt < 64) begin
                addr_log[we_cnt] = imem.waddr;
                data_log[we_cnt] = imem.wdata;
            end
            we_cnt = we_cnt + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; uio = 8'h00; ld_data = 8'h00; ena = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ld_data = b;
        uio[LD_STB_BIT] = 1'b1;
        repeat (5) @(negedge clk);
        uio[LD_STB_BIT] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_run(output int n);
        @(negedge clk);
        uio[RUN_BIT] = 1'b1;
        n = 0;
        while (core_rst_n !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        uio[RUN_BIT] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_stop(output int n);
        @(negedge clk);
        uio[STOP_BIT] = 1'b1;
        n = 0;
        while (core_rst_n !== 1'b0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        uio[STOP_BIT] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; uio = 8'h00; ld_data = 8'h00; ena = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (core_rst_n !== 1'b0 || loading !== 1'b1 || imem.we !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: core_rst_n=%b loading=%b we=%b, want 0 1 0", core_rst_n, loading, imem.we);
        end
        checks++;
        if (word_cnt !== 3'd0 || err_ovf !== 1'b0 || err_partial !== 1'b0 ||
            imem.waddr !== 2'd0 || imem.wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: word_cnt=%0d ovf=%b partial=%b waddr=%0d wdata=%h, want all 0",
                     word_cnt, err_ovf, err_partial, imem.waddr, imem.wdata);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (core_rst_n !== 1'b0 || loading !== 1'b1 || imem.we !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: core_rst_n=%b loading=%b we=%b, want 0 1 0", core_rst_n, loading, imem.we);
        end
    endtask

    task automatic test_load_word();
        int base;
        do_reset();
        base = we_cnt;
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h50); send_byte(8'h00);
        checks++;
        if (we_cnt - base !== 1) begin
            errors++;
            $display("FAIL load_we_count: got %0d pulses, want 1", we_cnt - base);
        end else begin
            checks++;
            if (addr_log[base] !== 2'd0 || data_log[base] !== 32'h00500513) begin
                errors++;
                $display("FAIL load_word: addr=%0d data=%h, want 0 00500513", addr_log[base], data_log[base]);
            end
        end
        checks++;
        if (word_cnt !== 3'd1 || imem.waddr !== 2'd1) begin
            errors++;
            $display("FAIL load_cnt: word_cnt=%0d waddr=%0d, want 1 1", word_cnt, imem.waddr);
        end
    endtask

    task automatic test_stop_idle();
        int n;
        do_reset();
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        do_stop(n);
        checks++;
        if (word_cnt !== 3'd1 || imem.waddr !== 2'd1 || loading !== 1'b1) begin
            errors++;
            $display("FAIL stop_in_idle: word_cnt=%0d waddr=%0d loading=%b, want 1 1 1", word_cnt, imem.waddr, loading);
        end
    endtask

    task automatic test_run_stop();
        int base, n;
        do_reset();
        base = we_cnt;
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        checks++;
        if (we_cnt - base !== 2 || word_cnt !== 3'd2) begin
            errors++;
            $display("FAIL two_words: pulses=%0d word_cnt=%0d, want 2 2", we_cnt - base, word_cnt);
        end else begin
            checks++;
            if (addr_log[base+1] !== 2'd1 || data_log[base+1] !== 32'h00100093) begin
                errors++;
                $display("FAIL second_word: addr=%0d data=%h, want 1 00100093", addr_log[base+1], data_log[base+1]);
            end
        end
        do_run(n);
        checks++;
        if (n > 4 || core_rst_n !== 1'b1 || loading !== 1'b0) begin
            errors++;
            $display("FAIL run_release: cycles=%0d core_rst_n=%b loading=%b, want <=4 1 0", n, core_rst_n, loading);
        end
        base = we_cnt;
        send_byte(8'h15); send_byte(8'h15);
        checks++;
        if (we_cnt - base !== 0 || core_rst_n !== 1'b1 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL run_ignores_bytes: pulses=%0d core_rst_n=%b ovf=%b, want 0 1 0", we_cnt - base, core_rst_n, err_ovf);
        end
        do_stop(n);
        checks++;
        if (n > 4 || core_rst_n !== 1'b0 || imem.waddr !== 2'd0 || word_cnt !== 3'd0 || loading !== 1'b1) begin
            errors++;
            $display("FAIL stop_rearm: cycles=%0d core_rst_n=%b waddr=%0d word_cnt=%0d loading=%b, want <=4 0 0 0 1",
                     n, core_rst_n, imem.waddr, word_cnt, loading);
        end
    endtask

    task automatic test_partial();
        int base, n;
        do_reset();
        base = we_cnt;
        send_byte(8'h15); send_byte(8'h01);
        do_run(n);
        checks++;
        if (err_partial !== 1'b1 || we_cnt - base !== 0 || core_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL partial_run: partial=%b pulses=%0d core_rst_n=%b, want 1 0 1", err_partial, we_cnt - base, core_rst_n);
        end
        do_stop(n);
        base = we_cnt;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        checks++;
        if (we_cnt - base !== 1 || data_log[base] !== 32'hDDCCBBAA || addr_log[base] !== 2'd0 || err_partial !== 1'b1) begin
            errors++;
            $display("FAIL partial_discard: pulses=%0d data=%h addr=%0d partial=%b, want 1 ddccbbaa 0 1",
                     we_cnt - base, data_log[base], addr_log[base], err_partial);
        end
    endtask

    task automatic test_overflow();
        int base, n;
        logic [31:0] exp_w;
        do_reset();
        base = we_cnt;
        for (int i = 0; i < 16; i++) send_byte(8'(i + 8'h40));
        checks++;
        if (we_cnt - base !== 4 || word_cnt !== 3'd4 || imem.waddr !== 2'd0) begin
            errors++;
            $display("FAIL fill: pulses=%0d word_cnt=%0d waddr=%0d, want 4 4 0", we_cnt - base, word_cnt, imem.waddr);
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_w = {8'(8'h43 + 4*k), 8'(8'h42 + 4*k), 8'(8'h41 + 4*k), 8'(8'h40 + 4*k)};
                checks++;
                if (addr_log[base+k] !== 2'(k) || data_log[base+k] !== exp_w) begin
                    errors++;
                    $display("FAIL fill_word%0d: addr=%0d data=%h, want %0d %h", k, addr_log[base+k], data_log[base+k], k, exp_w);
                end
            end
        end
        send_byte(8'h99);
        checks++;
        if (err_ovf !== 1'b1 || we_cnt - base !== 4 || word_cnt !== 3'd4 || loading !== 1'b1) begin
            errors++;
            $display("FAIL overflow: ovf=%b pulses=%0d word_cnt=%0d loading=%b, want 1 4 4 1", err_ovf, we_cnt - base, word_cnt, loading);
        end
        do_run(n);
        do_stop(n);
        checks++;
        if (err_ovf !== 1'b1 || word_cnt !== 3'd0 || err_partial !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b word_cnt=%0d partial=%b, want 1 0 0", err_ovf, word_cnt, err_partial);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        send_byte(8'h11); send_byte(8'h22);
        do_reset();
        base = we_cnt;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        checks++;
        if (we_cnt - base !== 1 || addr_log[base] !== 2'd0 || data_log[base] !== 32'h04030201) begin
            errors++;
            $display("FAIL reset_mid: pulses=%0d addr=%0d data=%h, want 1 0 04030201", we_cnt - base, addr_log[base], data_log[base]);
        end
        do_reset();
        base = we_cnt;
        ena = 1'b0;
        send_byte(8'hEE);
        ena = 1'b1;
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
        checks++;
        if (we_cnt - base !== 1 || addr_log[base] !== 2'd0 || data_log[base] !== 32'h0D0C0B0A || word_cnt !== 3'd1) begin
            errors++;
            $display("FAIL ena_off_byte: pulses=%0d addr=%0d data=%h word_cnt=%0d, want 1 0 0d0c0b0a 1",
                     we_cnt - base, addr_log[base], data_log[base], word_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; uio = 8'h00; ld_data = 8'h00;
        test_reset();
        test_load_word();
        test_stop_idle();
        test_run_stop();
        test_partial();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
